led_matrix_scan: RTL and testbench
==================================

Name: led_matrix_scan

Overview:
- Downstream of the SGA game core; consumes its 36-bit `leds` frame (6x6 board) and drives a physically multiplexed 6x6 LED matrix.
- Scans one row at a time with anti-ghosting blanking between rows.
- Double-buffers the frame so a game update never tears the display mid-scan.
- Exports a frame-done pulse the core may use as a render/refresh tick.

Parameters:
- ROWS, 6, number of matrix rows.
- COLS, 6, number of matrix columns.
- TICKS_PER_ROW, 50000, clock cycles per row slot (1 ms at 50 MHz). Legal range: at least BLANK_TICKS+1.
- BLANK_TICKS, 500, cycles at the start of each row slot with all outputs off. Legal range: at least 1.

Ports:
- clock  in  1  system clock, 50 MHz.
- restart  in  1  asynchronous active-high reset.
- enable  in  1  scan enable; 0 blanks the matrix.
- frame  in  ROWS*COLS  board image. Bit index is r*COLS+c; 1 means LED on.
- frame_valid  in  1  one-cycle strobe that captures `frame` into the pending buffer.
- row_out  out  ROWS  row anodes, one-hot, active-high.
- col_out  out  COLS  column cathodes, active-low (0 means LED lit).
- frame_done  out  1  one-cycle pulse when the last row slot completes.
- db_row  out  3  current row index.
- db_state  out  2  FSM state encoding: IDLE=0, BLANK=1, DRIVE=2.

Behaviour:
- Reset (async, any time) sets:
  - state=IDLE, row=0, tick=0;
  - pending and display buffers all 0, pending_flag=0;
  - row_out=0, col_out=all 1, frame_done=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Pending buffer:
  - frame_valid=1 loads pending<=frame and sets pending_flag.
  - The last strobe before the copy wins.
- Display buffer:
  - Updated only at a frame boundary, i.e. entering BLANK for row 0 (including leaving IDLE).
  - If pending_flag=1 at that point: display<=pending, clear pending_flag.
  - If frame_valid coincides with the boundary cycle, `frame` is bypassed directly into display and pending_flag stays 0.
- FSM:
  - IDLE:
    - row_out=0, col_out=all 1, tick=0, row=0.
    - If enable=1, go to BLANK on the next cycle (boundary copy happens).
  - BLANK:
    - row_out=0, col_out=all 1; tick increments.
    - When tick=BLANK_TICKS-1, go to DRIVE with tick continuing to increment.
  - DRIVE:
    - row_out bit `row` = 1; col_out[c] = ~display[row*COLS+c].
    - When tick=TICKS_PER_ROW-1: tick<=0, go to BLANK.
    - If row=ROWS-1: row wraps to 0, frame_done pulses for exactly that cycle, and the boundary copy applies. Otherwise row<=row+1.
- Any state with enable=0 goes to IDLE on the next cycle:
  - outputs off in that next cycle;
  - row and tick cleared;
  - no frame_done pulse;
  - pending buffer preserved.
- Row slot length is exactly TICKS_PER_ROW cycles. Full frame is ROWS*TICKS_PER_ROW cycles. frame_done period equals the frame length.
- At most one row_out bit is ever high. row_out and col_out change in the same cycle.
- tick is a counter of width ceil(log2(TICKS_PER_ROW)); row counts 0..ROWS-1, never ROWS.

Test Plan:
Bench parameters: TICKS_PER_ROW=8, BLANK_TICKS=2.
1. Pulse restart with enable=1 and frame_valid active.
   -> row_out=0, col_out=6'b111111, db_state=0, frame_done=0 during reset. First BLANK occurs 1 cycle after release.
2. Load frame=36'h0000_0003F (row 0 all on) with enable=1.
   -> Row 0 DRIVE cycles 2..7: row_out=6'b000001, col_out=6'b000000.
   -> Rows 1..5: col_out=6'b111111.
   -> frame_done pulses every 48 cycles.
3. Strobe frame_valid with a new pattern while row 3 is in DRIVE.
   -> Rows 3..5 keep the old image; the new image appears from the next row 0.
4. frame_valid in the same cycle as the row-5 to row-0 wrap.
   -> The new frame is shown in row 0 of that very frame.
5. Drop enable during row 2 DRIVE for 5 cycles, then re-enable.
   -> Outputs off the next cycle, db_row=0, no frame_done pulse; scan restarts at row 0 BLANK.
6. Assert restart mid-DRIVE of row 4.
   -> Outputs go off immediately (asynchronous). After release the display buffer is 0: all col_out=1 for the whole frame.

Source files
------------

// File: rtl/led_matrix_scan_if.sv
// led_matrix_scan_if: frame input and matrix drive signals between the game core and the LED scanner.
interface led_matrix_scan_if #(
    parameter int ROWS = 6,
    parameter int COLS = 6
);
    logic                   enable;
    logic [ROWS*COLS-1:0]   frame;
    logic                   frame_valid;
    logic [ROWS-1:0]        row_out;
    logic [COLS-1:0]        col_out;
    logic                   frame_done;
    logic [2:0]             db_row;
    logic [1:0]             db_state;
    modport master (
        output enable, frame, frame_valid,
        input  row_out, col_out, frame_done, db_row, db_state
    );
    modport slave (
        input  enable, frame, frame_valid,
        output row_out, col_out, frame_done, db_row, db_state
    );
endinterface

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-multiplexed LED matrix driver with per-row blanking and a
// double-buffered frame that only swaps at frame boundaries.
module led_matrix_scan #(
    parameter int ROWS          = 6,
    parameter int COLS          = 6,
    parameter int TICKS_PER_ROW = 50000,
    parameter int BLANK_TICKS   = 500
) (
    input logic            clock,
    input logic            restart,
    led_matrix_scan_if.slave bus
);
    localparam int TW = $clog2(TICKS_PER_ROW);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_ROW - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [2:0]    ROW_LAST   = 3'(ROWS - 1);

    logic [1:0]           state_q, state_d;
    logic [2:0]           row_q, row_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [ROWS*COLS-1:0] pend_q, pend_d, disp_q, disp_d;
    logic                 pflag_q, pflag_d;
    logic [ROWS-1:0]      row_out_q;
    logic [COLS-1:0]      col_out_q;
    logic                 done_q, done_d;
    logic                 last_tick, wrap, boundary;

    always_comb begin
        last_tick = tick_q == TICK_LAST;
        wrap      = state_q == S_DRIVE && last_tick && row_q == ROW_LAST;
        // a frame boundary is entering row 0 blanking, whether from idle or from the last row
        boundary  = bus.enable && (state_q == S_IDLE || wrap);
        state_d   = !bus.enable ? S_IDLE :
                    state_q == S_IDLE  ? S_BLANK :
                    state_q == S_BLANK ? (tick_q == BLANK_LAST ? S_DRIVE : S_BLANK) :
                    last_tick ? S_BLANK : S_DRIVE;
        tick_d    = (!bus.enable || state_q == S_IDLE || (state_q == S_DRIVE && last_tick)) ? '0 : tick_q + 1'b1;
        row_d     = (!bus.enable || state_q == S_IDLE || wrap) ? '0 :
                    (state_q == S_DRIVE && last_tick) ? row_q + 3'd1 : row_q;
        pend_d    = bus.frame_valid ? bus.frame : pend_q;
        pflag_d   = !boundary && (bus.frame_valid || pflag_q);
        disp_d    = !boundary ? disp_q : bus.frame_valid ? bus.frame : pflag_q ? pend_q : disp_q;
        done_d    = bus.enable && wrap;
    end

    // drive registers are loaded from next-state values so they line up with state_q
    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            tick_q    <= '0;
            pend_q    <= '0;
            disp_q    <= '0;
            pflag_q   <= 1'b0;
            row_out_q <= '0;
            col_out_q <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            pflag_q   <= pflag_d;
            row_out_q <= state_d == S_DRIVE ? ROWS'(1) << row_d : '0;
            col_out_q <= state_d == S_DRIVE ? ~disp_d[row_d*COLS +: COLS] : '1;
            done_q    <= done_d;
        end
    end

    assign bus.row_out    = row_out_q;
    assign bus.col_out    = col_out_q;
    assign bus.frame_done = done_q;
    assign bus.db_row     = row_q;
    assign bus.db_state   = state_q;
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed and random stimulus against a frame-position model of the scanner.
module tb_led_matrix_scan;
    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int TPR   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ROWS * TPR;

    logic clock = 1'b0;
    logic restart = 1'b1;
    int n_assert = 0;
    int n_fail = 0;

    led_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    led_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .TICKS_PER_ROW(TPR), .BLANK_TICKS(BLANK)) dut (
        .clock(clock),
        .restart(restart),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // model: position within the frame, 0..FRAME-1, plus the two image buffers
    bit m_active;
    int m_pos;
    logic [35:0] m_disp, m_pend;
    bit m_flag, m_done;

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_disp = '0; m_pend = '0; m_flag = 0; m_done = 0;
    endtask

    task automatic model_edge(bit en, bit fv, logic [35:0] fr);
        bit bnd = en && (!m_active || m_pos == FRAME - 1);
        m_done = en && m_active && m_pos == FRAME - 1;
        if (bnd) begin
            m_disp = fv ? fr : m_flag ? m_pend : m_disp;
            m_flag = 0;
        end else if (fv) m_flag = 1;
        if (fv) m_pend = fr;
        if (!en) begin m_active = 0; m_pos = 0; end
        else if (!m_active) begin m_active = 1; m_pos = 0; end
        else m_pos = (m_pos + 1) % FRAME;
    endtask

    task automatic check_all(string ph);
        int row = m_pos / TPR;
        bit drive = m_active && (m_pos % TPR) >= BLANK;
        logic [ROWS-1:0] er = '0;
        logic [COLS-1:0] ec = '1;
        if (drive) begin
            er[row] = 1'b1;
            for (int c = 0; c < COLS; c++) ec[c] = ~m_disp[row*COLS + c];
        end
        chk({ph, ".row_out"}, 64'(bus.row_out), 64'(er));
        chk({ph, ".col_out"}, 64'(bus.col_out), 64'(ec));
        chk({ph, ".frame_done"}, 64'(bus.frame_done), 64'(m_done));
        chk({ph, ".db_row"}, 64'(bus.db_row), 64'(m_active ? row : 0));
        chk({ph, ".db_state"}, 64'(bus.db_state), 64'(!m_active ? 0 : drive ? 2 : 1));
    endtask

    task automatic cyc(bit en, bit fv, logic [35:0] fr, string ph);
        bus.enable = en; bus.frame_valid = fv; bus.frame = fr;
        @(posedge clock);
        model_edge(en, fv, fr);
        #1 check_all(ph);
    endtask

    task automatic run_to(int p, string ph);
        for (int k = 0; k < 2*FRAME && !(m_active && m_pos == p); k++) cyc(1, 0, rnd36(), ph);
    endtask

    initial begin
        bus.enable = 1; bus.frame_valid = 1; bus.frame = rnd36();
        model_reset();
        repeat (3) begin @(posedge clock); #1 check_all("reset"); end
        restart = 0;
        cyc(1, 0, rnd36(), "first_blank");
        run_to(3, "load");
        cyc(1, 1, 36'h0_0000_003F, "load");
        repeat (2*FRAME) cyc(1, 0, rnd36(), "row0_on");
        run_to(3*TPR + 3, "mid_strobe");
        cyc(1, 1, rnd36(), "mid_strobe");
        repeat (FRAME + TPR) cyc(1, 0, rnd36(), "mid_strobe");
        run_to(10, "last_wins");
        cyc(1, 1, rnd36(), "last_wins");
        run_to(20, "last_wins");
        cyc(1, 1, rnd36(), "last_wins");
        repeat (FRAME) cyc(1, 0, rnd36(), "last_wins");
        run_to(20, "bypass");
        cyc(1, 1, rnd36(), "bypass");
        run_to(FRAME - 1, "bypass");
        cyc(1, 1, rnd36(), "bypass");
        repeat (FRAME) cyc(1, 0, rnd36(), "bypass");
        run_to(2*TPR + 3, "disable");
        cyc(0, 0, rnd36(), "disable");
        cyc(0, 1, rnd36(), "disable");
        repeat (3) cyc(0, 0, rnd36(), "disable");
        repeat (FRAME + 4) cyc(1, 0, rnd36(), "reenable");
        run_to(FRAME - 1, "disable_wrap");
        cyc(0, 0, rnd36(), "disable_wrap");
        repeat (FRAME) cyc(1, 0, rnd36(), "disable_wrap");
        run_to(4*TPR + 4, "async_reset");
        #2 restart = 1;
        #1;
        chk("async_reset.row_out", 64'(bus.row_out), 64'(0));
        chk("async_reset.col_out", 64'(bus.col_out), 64'(6'h3F));
        chk("async_reset.frame_done", 64'(bus.frame_done), 64'(0));
        chk("async_reset.db_state", 64'(bus.db_state), 64'(0));
        chk("async_reset.db_row", 64'(bus.db_row), 64'(0));
        model_reset();
        repeat (2) @(posedge clock);
        #1 restart = 0;
        repeat (FRAME + 2) cyc(1, 0, rnd36(), "post_reset");
        repeat (600) cyc($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0, rnd36(), "random");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
